pin_pattern_gen: RTL and testbench
==================================

# pin_pattern_gen

Parametrised board I/O pattern generator for bring-up of the FPGA pin map. Drives N_PINS outputs with one of eight selectable test patterns (static high/low, walking one/zero, binary count, checkerboard, blink, bounce), advancing at a prescaled rate so each pin can be checked visually or on a logic analyser. It sits directly behind the top-level pin assignments and replaces fixed constant-drive pin checks.

## Interface
Parameters:
- N_PINS, 40, number of driven pins; legal range 2..64
- PRESCALE, 12000000, clk cycles per pattern step; legal range 2..2^32-1
- POS_W, $clog2(N_PINS), width of pos output (derived, not overridden)

Ports:
- clk  input  1  system clock; all state on rising edge
- rst  input  1  asynchronous, active-high reset
- mode  input  3  pattern select (see Operation)
- hold  input  1  1 = freeze pattern; prescaler keeps running
- pins  output  N_PINS  registered pattern output, bit 0 = pin 0
- tick  output  1  one-cycle pulse, high the cycle after each pattern step edge
- pos  output  POS_W  current walking/bounce index (0 in other modes)

## Operation
- Internal state: cnt (32-bit prescaler), mode_q (3), init_q (1), pos, dir (1 = up), phase (1), val (N_PINS).
- Reset (async): pins=0, tick=0, pos=0, cnt=0, mode_q=0, dir=1, phase=0, val=0, init_q=1.
- Load event: init_q==1 or mode!=mode_q at an edge. On load: mode_q<=mode, init_q<=0, cnt<=0, pos<=0, dir<=1, phase<=0, val<=0, tick<=0, pins<=start pattern of new mode. Load has priority over step and hold.
- Step event: no load, cnt==PRESCALE-1. cnt<=0; tick<=1; if hold==0 the pattern advances and pins updates at this edge. If hold==1 pattern and pins unchanged, tick still pulses.
- Otherwise cnt<=cnt+1, tick<=0.
- Modes (start pattern; per-step update):
- 0 all-high: all ones; no change.
- 1 all-low: all zeros; no change.
- 2 walking one: pins=1<<pos; pos wraps N_PINS-1 -> 0.
- 3 walking zero: pins=~(1<<pos); same pos sequence.
- 4 binary count: pins=val; val+1 modulo 2^N_PINS (all ones -> 0).
- 5 checkerboard: phase 0 -> even bits 1 (…0101); phase toggles, phase 1 -> odd bits 1.
- 6 blink: phase 0 -> all ones, phase 1 -> all zeros; phase toggles.
- 7 bounce: pins=1<<pos; pos moves in dir; at pos==N_PINS-1 with dir up, dir<=0 and pos<=N_PINS-2; at pos==0 with dir down, dir<=1 and pos<=1. Sequence 0,1,…,N-1,N-2,…,0,1,… (endpoints shown once).
- pos output = pos register in modes 2,3,7; forced 0 in others.
- Unused widths: val and pins never wider than N_PINS; no X on any output after reset.

## Timing
- Pattern step period exactly PRESCALE clk cycles from a load: first step edge is the PRESCALE-th edge after the load edge.
- pins updates on the step edge itself (zero added latency); tick high during the following cycle only.
- Load: pins shows the new mode's start pattern the cycle after the edge where mode differs from mode_q; prescaler restarts from that edge.
- First edge after rst deasserts is a load (init_q), so pins reaches the start pattern one cycle after reset release regardless of mode.
- Mode change coincident with a step: load wins, no tick, no advance.
- hold toggled mid-period: affects only the next step edge; cnt unaffected.
- rst asserted mid-operation: all outputs to reset values immediately (asynchronous), independent of clk.

## Test plan
- N_PINS=8, PRESCALE=4, mode=0, release rst -> pins=0x00 during reset, 0xFF one cycle after release, tick never high except every 4 cycles, pins stays 0xFF.
- mode=2 -> pins 0x01,0x02,…,0x80,0x01 at 4-cycle intervals; pos 0..7 then 0; tick pulse the cycle after each change.
- mode=7 -> pins 0x01,0x02,…,0x80,0x40,…,0x01,0x02; pos 0..7..0..1.
- mode=4 run 256 steps -> pins counts 0x00..0xFF then wraps to 0x00; mode=5 -> 0x55,0xAA,0x55.
- mode=6 with hold=1 after two steps -> pins frozen, tick keeps pulsing every 4 cycles; hold=0 -> blinking resumes at next step.
- mode 2 at pos=5, change to 3 on a step edge -> no tick, next cycle pins=0xFE, pos=0; assert rst mid-period -> pins=0x00, tick=0 immediately.

Source files
------------

// File: rtl/pin_pattern_gen.sv
// pin_pattern_gen: board I/O pattern generator for pin-map bring-up.
// Drives N_PINS outputs with one of eight test patterns and advances the
// pattern once every PRESCALE clock cycles.
//
// Ports:
//   clk   - system clock, all state updates on the rising edge
//   rst   - asynchronous active-high reset
//   mode  - pattern select (0 high, 1 low, 2 walk-1, 3 walk-0, 4 count,
//           5 checkerboard, 6 blink, 7 bounce)
//   hold  - 1 freezes the pattern; the prescaler keeps running
//   pins  - registered pattern output, bit 0 = pin 0
//   tick  - one-cycle pulse in the cycle after each step edge
//   pos   - walking/bounce index in modes 2, 3, 7; 0 otherwise
module pin_pattern_gen #(
    parameter int unsigned N_PINS   = 40,
    parameter int unsigned PRESCALE = 12000000,
    parameter int unsigned POS_W    = $clog2(N_PINS)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [2:0]        mode,
    input  logic              hold,
    output logic [N_PINS-1:0] pins,
    output logic              tick,
    output logic [POS_W-1:0]  pos
);

    localparam int unsigned CNT_W = 32;
    localparam int unsigned HALF  = (N_PINS + 1) / 2;

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(PRESCALE - 1);
    localparam logic [POS_W-1:0] POS_LAST = POS_W'(N_PINS - 1);
    localparam logic [POS_W-1:0] POS_PREV = POS_W'(N_PINS - 2);

    // Even-bit checkerboard mask (...0101), trimmed to N_PINS bits.
    localparam logic [2*HALF-1:0]  EVEN_REP  = {HALF{2'b01}};
    localparam logic [N_PINS-1:0]  EVEN_MASK = EVEN_REP[N_PINS-1:0];

    localparam logic [2:0] M_HIGH  = 3'd0;
    localparam logic [2:0] M_LOW   = 3'd1;
    localparam logic [2:0] M_WALK1 = 3'd2;
    localparam logic [2:0] M_WALK0 = 3'd3;
    localparam logic [2:0] M_COUNT = 3'd4;
    localparam logic [2:0] M_CHECK = 3'd5;
    localparam logic [2:0] M_BLINK = 3'd6;
    localparam logic [2:0] M_BOUNC = 3'd7;

    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [2:0]        mode_q, mode_d;
    logic              init_q, init_d;
    logic [POS_W-1:0]  pos_q, pos_d;
    logic              dir_q, dir_d;
    logic              phase_q, phase_d;
    logic [N_PINS-1:0] val_q, val_d;
    logic [N_PINS-1:0] pins_d;
    logic              tick_d;
    logic [POS_W-1:0]  pos_out_d;
    logic              load_c;

    // Output pattern as a pure function of the pattern state.
    function automatic logic [N_PINS-1:0] pattern(
        input logic [2:0]        m,
        input logic [POS_W-1:0]  p,
        input logic              ph,
        input logic [N_PINS-1:0] v
    );
        logic [N_PINS-1:0] one_hot;
        logic [N_PINS-1:0] res;
        one_hot = N_PINS'(1) << p;
        res     = '0;
        case (m)
            M_HIGH:  res = '1;
            M_LOW:   res = '0;
            M_WALK1: res = one_hot;
            M_WALK0: res = ~one_hot;
            M_COUNT: res = v;
            M_CHECK: res = ph ? ~EVEN_MASK : EVEN_MASK;
            M_BLINK: res = ph ? '0 : '1;
            M_BOUNC: res = one_hot;
        endcase
        return res;
    endfunction

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q   <= '0;
            mode_q  <= 3'd0;
            init_q  <= 1'b1;
            pos_q   <= '0;
            dir_q   <= 1'b1;
            phase_q <= 1'b0;
            val_q   <= '0;
            pins    <= '0;
            tick    <= 1'b0;
            pos     <= '0;
        end else begin
            cnt_q   <= cnt_d;
            mode_q  <= mode_d;
            init_q  <= init_d;
            pos_q   <= pos_d;
            dir_q   <= dir_d;
            phase_q <= phase_d;
            val_q   <= val_d;
            pins    <= pins_d;
            tick    <= tick_d;
            pos     <= pos_out_d;
        end
    end

    // Next-state: load beats step, step beats free-running count.
    always_comb begin
        cnt_d   = cnt_q + CNT_W'(1);
        tick_d  = 1'b0;
        mode_d  = mode_q;
        init_d  = init_q;
        pos_d   = pos_q;
        dir_d   = dir_q;
        phase_d = phase_q;
        val_d   = val_q;
        load_c  = init_q || (mode != mode_q);

        if (load_c) begin
            mode_d  = mode;
            init_d  = 1'b0;
            cnt_d   = '0;
            pos_d   = '0;
            dir_d   = 1'b1;
            phase_d = 1'b0;
            val_d   = '0;
        end else if (cnt_q == CNT_LAST) begin
            cnt_d  = '0;
            tick_d = 1'b1;
            if (!hold) begin
                case (mode_q)
                    M_WALK1, M_WALK0: begin
                        pos_d = (pos_q == POS_LAST) ? '0 : pos_q + POS_W'(1);
                    end
                    M_COUNT: begin
                        val_d = val_q + N_PINS'(1);
                    end
                    M_CHECK, M_BLINK: begin
                        phase_d = ~phase_q;
                    end
                    M_BOUNC: begin
                        // Reflect at the ends so each endpoint is shown once.
                        if (dir_q) begin
                            if (pos_q == POS_LAST) begin
                                dir_d = 1'b0;
                                pos_d = POS_PREV;
                            end else begin
                                pos_d = pos_q + POS_W'(1);
                            end
                        end else begin
                            if (pos_q == '0) begin
                                dir_d = 1'b1;
                                pos_d = POS_W'(1);
                            end else begin
                                pos_d = pos_q - POS_W'(1);
                            end
                        end
                    end
                    default: begin
                    end
                endcase
            end
        end
    end

    // Output next values derived from the next pattern state.
    always_comb begin
        pins_d    = pattern(mode_d, pos_d, phase_d, val_d);
        pos_out_d = '0;
        if (mode_d == M_WALK1 || mode_d == M_WALK0 || mode_d == M_BOUNC) begin
            pos_out_d = pos_d;
        end
    end

endmodule

// File: tb/tb_pin_pattern_gen.sv
// Directed bench for pin_pattern_gen with N_PINS=8, PRESCALE=4.
module tb_pin_pattern_gen;

    localparam int unsigned NP = 8;
    localparam int unsigned PS = 4;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [2:0] mode = 3'd0;
    logic       hold = 1'b0;
    logic [7:0] pins;
    logic       tick;
    logic [2:0] pos;

    always #5 clk = ~clk;

    pin_pattern_gen #(
        .N_PINS  (NP),
        .PRESCALE(PS)
    ) dut (
        .clk (clk),
        .rst (rst),
        .mode(mode),
        .hold(hold),
        .pins(pins),
        .tick(tick),
        .pos (pos)
    );

    typedef struct {
        logic [2:0] mode;
        logic       hold;
        int         edges;
        logic [7:0] pins;
        logic [2:0] pos;
        logic       tick;
    } vec_t;

    vec_t vecs[$];
    int   tests = 0;
    int   fails = 0;

    function automatic void add(input logic [2:0] m, input logic h, input int e,
                                input logic [7:0] p, input logic [2:0] ps, input logic t);
        vec_t v;
        v.mode = m; v.hold = h; v.edges = e; v.pins = p; v.pos = ps; v.tick = t;
        vecs.push_back(v);
    endfunction

    task automatic check(input string name, input logic [7:0] ep,
                         input logic [2:0] epos, input logic et);
        tests++;
        if (pins !== ep || pos !== epos || tick !== et) begin
            fails++;
            $display("FAIL %s: got pins=%h pos=%0d tick=%b, expected pins=%h pos=%0d tick=%b",
                     name, pins, pos, tick, ep, epos, et);
        end
    endtask

    task automatic run_edges(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    initial begin
        int bounce[16];
        bounce = '{1, 2, 3, 4, 5, 6, 7, 6, 5, 4, 3, 2, 1, 0, 1, 2};

        // mode 0: start pattern on the load edge, tick every 4 cycles, no change
        add(3'd0, 1'b0, 1, 8'hFF, 3'd0, 1'b0);
        add(3'd0, 1'b0, 3, 8'hFF, 3'd0, 1'b0);
        add(3'd0, 1'b0, 1, 8'hFF, 3'd0, 1'b1);
        add(3'd0, 1'b0, 1, 8'hFF, 3'd0, 1'b0);
        add(3'd0, 1'b0, 3, 8'hFF, 3'd0, 1'b1);
        // mode 2: walking one with wrap
        add(3'd2, 1'b0, 1, 8'h01, 3'd0, 1'b0);
        for (int i = 1; i <= 8; i++) begin
            logic [7:0] w;
            w = 8'h01 << (i % 8);
            add(3'd2, 1'b0, 4, w, 3'(i % 8), 1'b1);
        end
        // mode 7: bounce
        add(3'd7, 1'b0, 1, 8'h01, 3'd0, 1'b0);
        for (int i = 0; i < 16; i++) begin
            logic [7:0] w;
            w = 8'h01 << bounce[i];
            add(3'd7, 1'b0, 4, w, 3'(bounce[i]), 1'b1);
        end
        // mode 4: full count and wrap
        add(3'd4, 1'b0, 1, 8'h00, 3'd0, 1'b0);
        for (int i = 1; i <= 256; i++) begin
            add(3'd4, 1'b0, 4, 8'(i), 3'd0, 1'b1);
        end
        // mode 5: checkerboard
        add(3'd5, 1'b0, 1, 8'h55, 3'd0, 1'b0);
        add(3'd5, 1'b0, 4, 8'hAA, 3'd0, 1'b1);
        add(3'd5, 1'b0, 4, 8'h55, 3'd0, 1'b1);
        // mode 6: blink, then hold freezes while tick keeps pulsing
        add(3'd6, 1'b0, 1, 8'hFF, 3'd0, 1'b0);
        add(3'd6, 1'b0, 4, 8'h00, 3'd0, 1'b1);
        add(3'd6, 1'b0, 4, 8'hFF, 3'd0, 1'b1);
        add(3'd6, 1'b1, 2, 8'hFF, 3'd0, 1'b0);
        add(3'd6, 1'b1, 2, 8'hFF, 3'd0, 1'b1);
        add(3'd6, 1'b1, 4, 8'hFF, 3'd0, 1'b1);
        add(3'd6, 1'b0, 4, 8'h00, 3'd0, 1'b1);
        add(3'd6, 1'b0, 4, 8'hFF, 3'd0, 1'b1);

        // reset state
        #12;
        check("reset", 8'h00, 3'd0, 1'b0);
        run_edges(1);
        check("reset_held", 8'h00, 3'd0, 1'b0);
        rst = 1'b0;

        for (int i = 0; i < vecs.size(); i++) begin
            mode = vecs[i].mode;
            hold = vecs[i].hold;
            run_edges(vecs[i].edges);
            check($sformatf("vec%0d_mode%0d", i, vecs[i].mode),
                  vecs[i].pins, vecs[i].pos, vecs[i].tick);
        end

        // mode change coincident with a step edge: load wins
        mode = 3'd2;
        hold = 1'b0;
        run_edges(1);
        check("m2_load", 8'h01, 3'd0, 1'b0);
        run_edges(20);
        check("m2_pos5", 8'h20, 3'd5, 1'b1);
        run_edges(3);
        check("m2_pre_step", 8'h20, 3'd5, 1'b0);
        mode = 3'd3;
        run_edges(1);
        check("m3_load_on_step", 8'hFE, 3'd0, 1'b0);
        run_edges(1);
        check("m3_no_late_tick", 8'hFE, 3'd0, 1'b0);
        run_edges(3);
        check("m3_first_step", 8'hFD, 3'd1, 1'b1);

        // asynchronous reset mid-cycle
        #2;
        rst = 1'b1;
        #1;
        check("async_reset", 8'h00, 3'd0, 1'b0);
        run_edges(2);
        check("async_reset_held", 8'h00, 3'd0, 1'b0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
